// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   Register offsets (word index mem_addr[3:2]), STATUS/CTRL bit positions,
//   the transmit state type and a helper that clamps the FIFO count to the
//   4-bit STATUS count field.
package mmio_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT    = 4;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Deep FIFOs would overflow the 4-bit field, so the display saturates at 15.
    function automatic logic [3:0] sat_count4(input int unsigned cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_if.sv
// Data-memory bus slice between the CPU load/store path and the UART.
//   master : CPU side, drives address/data/strobes, receives sel_hit/rdata
//   slave  : peripheral side, decodes and returns combinational read data
interface mmio_uart_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        sel_hit;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  sel_hit, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output sel_hit, mem_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head-of-queue output.
//   clk, rst     : clock, synchronous active-high reset (flushes the queue)
//   push, din    : enqueue; accepted when not full, or when full and popping
//   pop, dout    : dequeue; dout always shows the current head
//   full, empty  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        // Power-of-two depth: pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a store-fed TX FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : data-memory bus slave (decode, store commit, combinational read)
//   uart_txd  : registered serial output, idle high
//   irq       : level interrupt = irq_en && FIFO empty && transmitter idle
//
// state | meaning
// IDLE  | line high; pops the FIFO head when enabled and data is queued
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high) for CLK_DIV cycles
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    mmio_uart_if.slave bus,
    output logic       uart_txd,
    output logic       irq
);
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               ovf_q, ovf_d;
    logic               tx_en_q, tx_en_d;
    logic               irq_en_q, irq_en_d;

    logic               fifo_pop, fifo_full, fifo_empty;
    logic [7:0]         fifo_dout;
    logic [FCNT_W-1:0]  fifo_count;
    logic               wr_txdata, wr_status, wr_ctrl;
    logic               cnt_last, busy;
    logic [31:0]        status, rdata;
    logic               unused_bits;

    assign bus.sel_hit = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata   = bus.sel_hit && bus.mem_we && (bus.mem_addr[3:2] == REG_TXDATA);
    assign wr_status   = bus.sel_hit && bus.mem_we && (bus.mem_addr[3:2] == REG_STATUS);
    assign wr_ctrl     = bus.sel_hit && bus.mem_we && (bus.mem_addr[3:2] == REG_CTRL);
    assign unused_bits = &{1'b0, bus.mem_addr[1:0], bus.mem_wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (bus.mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy     = (state_q != IDLE);
    assign cnt_last = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_en_q && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase

        // Line level follows the next state so the pin is a clean flop output.
        txd_d = 1'b1;
        if (state_d == START) begin
            txd_d = 1'b0;
        end else if (state_d == DATA) begin
            txd_d = shift_d[0];
        end
    end

    always_comb begin
        ovf_d    = ovf_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        // A full-FIFO store is only dropped when nothing leaves in the same cycle.
        if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (wr_status && bus.mem_wdata[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_ctrl) begin
            tx_en_d  = bus.mem_wdata[CTRL_TX_EN];
            irq_en_d = bus.mem_wdata[CTRL_IRQ_EN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
            tx_en_q  <= tx_en_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_comb begin
        status                     = '0;
        status[STAT_FULL]          = fifo_full;
        status[STAT_EMPTY]         = fifo_empty;
        status[STAT_BUSY]          = busy;
        status[STAT_OVF]           = ovf_q;
        status[STAT_CNT +: 4]      = sat_count4(32'(fifo_count));

        rdata = '0;
        if (bus.sel_hit && bus.mem_re) begin
            case (bus.mem_addr[3:2])
                REG_STATUS: rdata = status;
                REG_CTRL: begin
                    rdata[CTRL_TX_EN]  = tx_en_q;
                    rdata[CTRL_IRQ_EN] = irq_en_q;
                end
                default: rdata = '0;
            endcase
        end
    end

    assign bus.mem_rdata = rdata;
    assign uart_txd      = txd_q;
    assign irq           = irq_en_q && fifo_empty && !busy;
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DIV   = 4;
    localparam int          FRAME = 10 * DIV;
    localparam int          SLOT  = FRAME + 1;

    logic clk, rst, uart_txd, irq;
    mmio_uart_if bus();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .uart_txd (uart_txd),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] stream_q[$];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_we    = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.mem_addr = a;
        bus.mem_re   = 1'b1;
        #1;
        d = bus.mem_rdata;
        bus.mem_re   = 1'b0;
    endtask

    task automatic add_vec(input string n, input logic [31:0] a, input logic we, input logic re,
                           input logic [31:0] wd, input logic es, input logic [31:0] er);
        vec_t v;
        v.name = n; v.addr = a; v.we = we; v.re = re;
        v.wdata = wd; v.exp_sel = es; v.exp_rdata = er;
        vecs.push_back(v);
    endtask

    // Reference line level t cycles after the first pop edge: each queued byte
    // occupies a 41-cycle slot (10 bits of DIV cycles, then one idle cycle).
    function automatic logic exp_txd(input int t);
        int f, r, b;
        logic [7:0] byt;
        f = t / SLOT;
        r = t % SLOT;
        if (f >= stream_q.size() || r >= FRAME) return 1'b1;
        b = r / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        byt = stream_q[f];
        return byt[b-1];
    endfunction

    // Caller sits just before the edge that brings time to offset t_start,
    // where offset 0 is the edge that pops the first byte of stream_q.
    task automatic run_stream(input int t_start, input logic irq_en, input string name);
        int n, errs, fb_t;
        logic [31:0] st;
        logic e_txd, e_busy, e_irq;
        logic g_txd, g_irq, g_busy, x_txd, x_irq, x_busy;
        n = stream_q.size();
        errs = 0; fb_t = 0;
        g_txd = 0; g_irq = 0; g_busy = 0; x_txd = 0; x_irq = 0; x_busy = 0;
        for (int t = t_start; t <= n * SLOT + 1; t++) begin
            @(posedge clk);
            #1;
            e_txd  = exp_txd(t);
            e_busy = (t < n * SLOT - 1) && ((t % SLOT) < FRAME);
            e_irq  = irq_en && (t >= n * SLOT - 1);
            rd(BASE + 32'h4, st);
            if (uart_txd !== e_txd || irq !== e_irq || st[2] !== e_busy) begin
                if (errs == 0) begin
                    fb_t = t; g_txd = uart_txd; g_irq = irq; g_busy = st[2];
                    x_txd = e_txd; x_irq = e_irq; x_busy = e_busy;
                end
                errs++;
            end
            if ((t % SLOT) == FRAME || t == n * SLOT + 1) begin
                total++;
                if (errs != 0) begin
                    bad++;
                    $display("FAIL %s slot %0d: %0d bad cycles, first t=%0d txd=%b want %b irq=%b want %b busy=%b want %b",
                             name, t / SLOT, errs, fb_t, g_txd, x_txd, g_irq, x_irq, g_busy, x_busy);
                end
                errs = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int errs, n;
        logic ie;

        bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_we = 1'b0; bus.mem_re = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_txd", 32'(uart_txd), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);

        add_vec("rd_status",   BASE + 32'h4, 0, 1, 0, 1, 32'h2);
        add_vec("rd_ctrl",     BASE + 32'h8, 0, 1, 0, 1, 32'h1);
        add_vec("rd_outside",  32'h0000_1000, 0, 1, 0, 0, 32'h0);
        add_vec("rd_txdata",   BASE, 0, 1, 0, 1, 32'h0);
        add_vec("rd_resv",     BASE + 32'hC, 0, 1, 0, 1, 32'h0);
        add_vec("no_re",       BASE + 32'h4, 0, 0, 0, 1, 32'h0);
        add_vec("wr_ctrl3",    BASE + 32'h8, 1, 0, 32'h3, 1, 32'h0);
        add_vec("rd_ctrl_lo",  BASE + 32'hA, 0, 1, 0, 1, 32'h3);
        add_vec("wr_resv",     BASE + 32'hC, 1, 0, 32'hFFFF_FFFF, 1, 32'h0);
        add_vec("wr_stat_nop", BASE + 32'h4, 1, 0, 32'hFFFF_FFF7, 1, 32'h0);
        add_vec("rd_status2",  BASE + 32'h4, 0, 1, 0, 1, 32'h2);
        add_vec("rd_other_hi", 32'hFFFE_0004, 0, 1, 0, 0, 32'h0);
        add_vec("rd_next_win", BASE + 32'h14, 0, 1, 0, 0, 32'h0);
        add_vec("wr_ctrl1",    BASE + 32'h8, 1, 0, 32'h1, 1, 32'h0);
        add_vec("rd_ctrl1",    BASE + 32'h8, 0, 1, 0, 1, 32'h1);
        foreach (vecs[i]) begin
            bus.mem_addr  = vecs[i].addr;
            bus.mem_wdata = vecs[i].wdata;
            bus.mem_we    = vecs[i].we;
            bus.mem_re    = vecs[i].re;
            #1;
            chk({vecs[i].name, "_sel"}, 32'(bus.sel_hit), 32'(vecs[i].exp_sel));
            chk({vecs[i].name, "_rdata"}, bus.mem_rdata, vecs[i].exp_rdata);
            if (vecs[i].we) begin
                @(posedge clk);
                #1;
            end
            bus.mem_we = 1'b0;
            bus.mem_re = 1'b0;
        end

        // Single byte straight into an idle transmitter.
        stream_q = {8'h55};
        wr(BASE, 32'h55);
        chk("single_prepop_txd", 32'(uart_txd), 32'h1);
        run_stream(0, 1'b0, "single");

        // Overflow while disabled, then drain eight frames.
        wr(BASE + 32'h8, 32'h0);
        for (int i = 1; i <= 9; i++) wr(BASE, 32'(i));
        rd(BASE + 32'h4, d);
        chk("ovf_status", d, 32'h89);
        stream_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        wr(BASE + 32'h8, 32'h1);
        run_stream(0, 1'b0, "ovf_drain");
        rd(BASE + 32'h4, d);
        chk("ovf_after_drain", d, 32'h0A);
        wr(BASE + 32'h4, 32'h8);
        rd(BASE + 32'h4, d);
        chk("ovf_cleared", d, 32'h02);

        // Push into a full FIFO on the very edge that pops it.
        wr(BASE + 32'h8, 32'h0);
        stream_q.delete();
        for (int i = 0; i < 9; i++) stream_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) wr(BASE, 32'(stream_q[i]));
        rd(BASE + 32'h4, d);
        chk("full_status", d, 32'h81);
        wr(BASE + 32'h8, 32'h1);
        wr(BASE, 32'(stream_q[8]));
        rd(BASE + 32'h4, d);
        chk("full_pushpop_status", d, 32'h85);
        run_stream(1, 1'b0, "full_pushpop");
        rd(BASE + 32'h4, d);
        chk("full_pushpop_end", d, 32'h02);

        // Disable in the middle of a frame: it finishes, the next byte stays queued.
        stream_q = {8'hA5};
        wr(BASE, 32'hA5);
        wr(BASE, 32'h3C);
        chk("dis_start_txd", 32'(uart_txd), 32'h0);
        errs = 0;
        for (int t = 1; t < 60; t++) begin
            if (t == 10) begin
                bus.mem_addr = BASE + 32'h8; bus.mem_wdata = 32'h0; bus.mem_we = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.mem_we = 1'b0;
            if (uart_txd !== exp_txd(t)) errs++;
        end
        chk("dis_frame_bad_cycles", 32'(errs), 32'h0);
        rd(BASE + 32'h4, d);
        chk("dis_status", d, 32'h10);
        stream_q = {8'h3C};
        wr(BASE + 32'h8, 32'h1);
        run_stream(0, 1'b0, "reenable");

        // Transmit-done interrupt.
        wr(BASE + 32'h8, 32'h3);
        chk("irq_idle_empty", 32'(irq), 32'h1);
        stream_q = {8'h00};
        wr(BASE, 32'h00);
        chk("irq_queued", 32'(irq), 32'h0);
        run_stream(0, 1'b1, "irq_frame");
        wr(BASE + 32'h8, 32'h1);
        chk("irq_disabled", 32'(irq), 32'h0);

        // Randomised bursts against the slot model.
        for (int r = 0; r < 6; r++) begin
            n  = int'($urandom_range(1, 8));
            ie = 1'($urandom_range(0, 1));
            wr(BASE + 32'h8, 32'h0);
            stream_q.delete();
            for (int i = 0; i < n; i++) begin
                stream_q.push_back(8'($urandom_range(0, 255)));
                wr(BASE, {24'h0, stream_q[i]});
            end
            wr(BASE + 32'h8, {30'h0, ie, 1'b1});
            run_stream(0, ie, $sformatf("rand%0d", r));
            rd(BASE + 32'h4, d);
            chk($sformatf("rand%0d_status", r), d, 32'h02);
        end

        // Reset in the middle of a frame with another byte still queued.
        wr(BASE + 32'h8, 32'h3);
        wr(BASE, 32'hFF);
        wr(BASE, 32'h00);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmid_txd", 32'(uart_txd), 32'h1);
        rd(BASE + 32'h4, d);
        chk("rstmid_status", d, 32'h02);
        rd(BASE + 32'h8, d);
        chk("rstmid_ctrl", d, 32'h01);
        chk("rstmid_irq", 32'(irq), 32'h0);
        errs = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (uart_txd !== 1'b1) errs++;
        end
        chk("rstmid_idle_cycles", 32'(errs), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
